// File: rtl/db_btn_bank.sv
// db_btn_bank: N-channel push-button conditioner.
// Sync, debounce, press/release/long/repeat pulses and toggle latch.
module db_btn_bank #(
  parameter int CLK_FREQ   = 200_000_000,
  parameter int N_BTN      = 2,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int DB_MS      = 20,
  parameter int LONG_MS    = 1000,
  parameter int REP_MS     = 200
) (
  input  logic             clk,
  input  logic             sys_rstn,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_BTN-1:0] rep_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_p,
  output logic [N_BTN-1:0] release_p,
  output logic [N_BTN-1:0] long_p,
  output logic [N_BTN-1:0] rep_p,
  output logic [N_BTN-1:0] toggle
);

  localparam int DB_CYC   = CLK_FREQ / 1000 * DB_MS;
  localparam int LONG_CYC = CLK_FREQ / 1000 * LONG_MS;
  localparam int REP_CYC  = CLK_FREQ / 1000 * REP_MS;
  localparam int DBW = $clog2(DB_CYC);
  localparam int HW  = $clog2(LONG_CYC + 1);
  localparam int RW  = $clog2(REP_CYC + 1);

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYC - 1);
  localparam logic [HW-1:0]  LONG_FULL = HW'(LONG_CYC);
  localparam logic [HW-1:0]  LONG_LAST = HW'(LONG_CYC - 1);
  localparam logic [RW-1:0]  REP_LAST  = RW'(REP_CYC - 1);
  localparam logic [N_BTN-1:0] IDLE = {N_BTN{ACTIVE_LOW}};

  logic [N_BTN-1:0] s1_q, s1_d;
  logic [N_BTN-1:0] s2_q, s2_d;
  logic [N_BTN-1:0] lvl_q, lvl_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] rel_q, rel_d;
  logic [N_BTN-1:0] long_q, long_d;
  logic [N_BTN-1:0] rep_q, rep_d;
  logic [N_BTN-1:0] tog_q, tog_d;
  logic [DBW-1:0]   db_cnt_q [N_BTN];
  logic [DBW-1:0]   db_cnt_d [N_BTN];
  logic [HW-1:0]    hold_q [N_BTN];
  logic [HW-1:0]    hold_d [N_BTN];
  logic [RW-1:0]    rcnt_q [N_BTN];
  logic [RW-1:0]    rcnt_d [N_BTN];

  logic [N_BTN-1:0] prs;
  logic [N_BTN-1:0] flip;

  assign prs = s2_q ^ IDLE;

  // flip: the new level has been stable for the full window
  always_comb begin
    flip = '0;
    for (int i = 0; i < N_BTN; i++) begin
      flip[i] = (prs[i] != lvl_q[i]) && (db_cnt_q[i] == DB_LAST);
    end
  end

  assign press_d = flip & prs;
  assign rel_d   = flip & ~prs;
  assign tog_d   = tog_q ^ press_d;
  assign s1_d    = btn_in;
  assign s2_d    = s1_q;

  always_comb begin
    lvl_d    = lvl_q ^ flip;
    long_d   = '0;
    rep_d    = '0;
    db_cnt_d = db_cnt_q;
    hold_d   = hold_q;
    rcnt_d   = rcnt_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (prs[i] == lvl_q[i] || flip[i]) begin
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
      // a release accepted this edge wins over long/repeat
      if (!lvl_q[i] || rel_d[i]) begin
        hold_d[i] = '0;
        rcnt_d[i] = '0;
      end else begin
        if (hold_q[i] != LONG_FULL) begin
          hold_d[i] = hold_q[i] + 1'b1;
        end
        long_d[i] = (hold_q[i] == LONG_LAST);
        if (hold_q[i] != LONG_FULL || !rep_en[i]) begin
          rcnt_d[i] = '0;
        end else if (rcnt_q[i] == REP_LAST) begin
          rep_d[i]  = 1'b1;
          rcnt_d[i] = '0;
        end else begin
          rcnt_d[i] = rcnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      s1_q    <= IDLE;
      s2_q    <= IDLE;
      lvl_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
      long_q  <= '0;
      rep_q   <= '0;
      tog_q   <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt_q[i] <= '0;
        hold_q[i]   <= '0;
        rcnt_q[i]   <= '0;
      end
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
      tog_q   <= tog_d;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        hold_q[i]   <= hold_d[i];
        rcnt_q[i]   <= rcnt_d[i];
      end
    end
  end

  assign btn_level = lvl_q;
  assign press_p   = press_q;
  assign release_p = rel_q;
  assign long_p    = long_q;
  assign rep_p     = rep_q;
  assign toggle    = tog_q;

endmodule

// File: tb/tb_db_btn_bank.sv
// tb_db_btn_bank: directed plus random checks of db_btn_bank
// against a timestamp-based reference model.
module tb_db_btn_bank;
  localparam int DB   = 20;
  localparam int LONG = 100;
  localparam int REP  = 30;

  logic       clk = 1'b0;
  logic       sys_rstn = 1'b1;
  logic [1:0] btn_in = 2'b11;
  logic [1:0] rep_en = 2'b00;
  logic [1:0] btn_level, press_p, release_p;
  logic [1:0] long_p, rep_p, toggle;

  always #5 clk = ~clk;

  db_btn_bank #(
    .CLK_FREQ(10_000), .N_BTN(2), .ACTIVE_LOW(1'b1),
    .DB_MS(2), .LONG_MS(10), .REP_MS(3)
  ) dut (
    .clk(clk), .sys_rstn(sys_rstn),
    .btn_in(btn_in), .rep_en(rep_en),
    .btn_level(btn_level), .press_p(press_p),
    .release_p(release_p), .long_p(long_p),
    .rep_p(rep_p), .toggle(toggle)
  );

  int checks = 0;
  int failures = 0;

  // model: edge index since reset, pin history, event timestamps
  int n;
  logic [1:0] pq[$];
  logic [1:0] m_lvl, m_tog;
  int dsince[2], press_n[2], rref[2];

  int c_press[2], c_rel[2], c_long[2], c_rep[2];
  int t_press[2], t_rel[2], t_long[2], t_rep1[2];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    n = 0;
    pq = {2'b11, 2'b11};
    m_lvl = 2'b00;
    m_tog = 2'b00;
    for (int i = 0; i < 2; i++) begin
      dsince[i]  = -1;
      press_n[i] = -1000000;
      rref[i]    = 0;
    end
  endtask

  task automatic clr_obs();
    for (int i = 0; i < 2; i++) begin
      c_press[i] = 0; c_rel[i] = 0; c_long[i] = 0; c_rep[i] = 0;
      t_press[i] = -1; t_rel[i] = -1; t_long[i] = -1; t_rep1[i] = -1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_level"}, btn_level, 0);
    chk({tag, "_press"}, press_p, 0);
    chk({tag, "_release"}, release_p, 0);
    chk({tag, "_long"}, long_p, 0);
    chk({tag, "_rep"}, rep_p, 0);
    chk({tag, "_toggle"}, toggle, 0);
  endtask

  task automatic do_reset(input int cyc);
    sys_rstn = 1'b0;
    #1;
    chk_zero("rst_now");
    repeat (cyc) begin
      @(posedge clk); #1;
      chk_zero("rst_hold");
    end
    sys_rstn = 1'b1;
    m_reset();
  endtask

  task automatic step(input logic [1:0] p, input logic [1:0] r);
    logic [1:0] prs, old, ep, er, el, erp;
    btn_in = p;
    rep_en = r;
    @(posedge clk); #1;
    n++;
    pq.push_back(p);
    prs = ~pq.pop_front();
    old = m_lvl;
    ep = 0; er = 0; el = 0; erp = 0;
    for (int i = 0; i < 2; i++) begin
      if (prs[i] == m_lvl[i]) begin
        dsince[i] = -1;
      end else begin
        if (dsince[i] < 0) dsince[i] = n;
        if (n - dsince[i] == DB - 1) begin
          m_lvl[i] = prs[i];
          dsince[i] = -1;
          if (prs[i]) ep[i] = 1'b1;
          else er[i] = 1'b1;
        end
      end
      if (ep[i]) begin
        press_n[i] = n;
        m_tog[i] = ~m_tog[i];
      end
      if (old[i] && !er[i]) begin
        if (n == press_n[i] + LONG) begin
          el[i] = 1'b1;
          rref[i] = n;
        end else if (n > press_n[i] + LONG) begin
          if (!r[i]) rref[i] = n;
          else if (n - rref[i] == REP) begin
            erp[i] = 1'b1;
            rref[i] = n;
          end
        end
      end
    end
    chk("level", btn_level, m_lvl);
    chk("press_p", press_p, ep);
    chk("release_p", release_p, er);
    chk("long_p", long_p, el);
    chk("rep_p", rep_p, erp);
    chk("toggle", toggle, m_tog);
    for (int i = 0; i < 2; i++) begin
      if (press_p[i]) begin c_press[i]++; t_press[i] = n; end
      if (release_p[i]) begin c_rel[i]++; t_rel[i] = n; end
      if (long_p[i]) begin c_long[i]++; t_long[i] = n; end
      if (rep_p[i]) begin
        if (c_rep[i] == 0) t_rep1[i] = n;
        c_rep[i]++;
      end
    end
  endtask

  initial begin
    int e, r0;
    int seg[2];
    logic [1:0] pin, re;

    // reset and idle
    clr_obs();
    do_reset(3);
    repeat (200) step(2'b11, 2'b00);
    chk("idle_events", c_press[0] + c_press[1] + c_rel[0] + c_rel[1], 0);

    // clean press ch0
    clr_obs();
    e = n + 1;
    repeat (60) step(2'b10, 2'b00);
    chk("clean_press_t", t_press[0], e + 21);
    chk("clean_press_n", c_press[0], 1);
    chk("clean_toggle", toggle[0], 1);
    chk("clean_ch1", c_press[1] + btn_level[1], 0);
    r0 = n + 1;
    repeat (40) step(2'b11, 2'b00);
    chk("clean_rel_t", t_rel[0], r0 + 21);

    // bounce
    clr_obs();
    repeat (5) begin
      repeat (7) step(2'b10, 2'b00);
      repeat (7) step(2'b11, 2'b00);
    end
    chk("bounce_quiet", c_press[0] + c_rel[0], 0);
    e = n + 1;
    repeat (40) step(2'b10, 2'b00);
    chk("bounce_press_t", t_press[0], e + 21);
    repeat (40) step(2'b11, 2'b00);

    // long press with repeat
    clr_obs();
    e = n + 1;
    repeat (400) step(2'b10, 2'b01);
    r0 = n + 1;
    repeat (40) step(2'b11, 2'b01);
    chk("long_t", t_long[0], e + 21 + 100);
    chk("long_n", c_long[0], 1);
    chk("rep1_t", t_rep1[0], e + 21 + 130);
    chk("rep_n", c_rep[0], 9);
    chk("long_rel_t", t_rel[0], r0 + 21);
    chk("long_rel_n", c_rel[0], 1);

    // long press without repeat
    clr_obs();
    repeat (400) step(2'b10, 2'b00);
    repeat (40) step(2'b11, 2'b00);
    chk("norep_long_n", c_long[0], 1);
    chk("norep_rep_n", c_rep[0], 0);

    // short presses ch1
    clr_obs();
    repeat (50) step(2'b01, 2'b11);
    repeat (40) step(2'b11, 2'b11);
    chk("short_press_n", c_press[1], 1);
    chk("short_rel_n", c_rel[1], 1);
    chk("short_long_n", c_long[1], 0);
    chk("short_tog1", toggle[1], 1);
    repeat (50) step(2'b01, 2'b11);
    repeat (40) step(2'b11, 2'b11);
    chk("short_tog2", toggle[1], 0);

    // random traffic
    seg[0] = 0; seg[1] = 0;
    pin = 2'b11; re = 2'b00;
    repeat (4000) begin
      for (int i = 0; i < 2; i++) begin
        if (seg[i] == 0) begin
          pin[i] = ~pin[i];
          if ($urandom_range(0, 1) == 0) seg[i] = $urandom_range(1, 25);
          else seg[i] = $urandom_range(20, 300);
        end
        seg[i]--;
      end
      if ($urandom_range(0, 99) == 0) re = 2'($urandom);
      step(pin, re);
    end
    repeat (60) step(2'b11, 2'b00);

    // reset mid-hold
    clr_obs();
    repeat (81) step(2'b10, 2'b00);
    chk("midhold_level", btn_level[0], 1);
    do_reset(3);
    clr_obs();
    e = n + 1;
    repeat (40) step(2'b10, 2'b00);
    chk("rst_press_t", t_press[0], e + 21);
    chk("rst_no_rel", c_rel[0], 0);
    repeat (40) step(2'b11, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
